// File: rtl/word_sprite_pkg.sv
// +----------------------------------------------------------------------+
// | word_sprite_pkg : shared types and default glyph dimensions          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package word_sprite_pkg;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    BLINK_SOLID = 2'd0,
    BLINK_ON    = 2'd1,
    BLINK_OFF   = 2'd2
  } blink_state_e;

  localparam int DEF_WORD_W    = 64;
  localparam int DEF_WORD_H    = 32;
  localparam int DEF_NUM_WORDS = 4;

endpackage

`default_nettype wire

// File: rtl/word_sprite_if.sv
// +----------------------------------------------------------------------+
// | word_sprite_if : raster, glyph-request and status signals            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface word_sprite_if #(
  parameter int NUM_WORDS = 4
);
  import word_sprite_pkg::*;

  localparam int SEL_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  logic             frame_start;
  logic             video_on;
  coord_t           pix_x;
  coord_t           pix_y;
  logic [SEL_W-1:0] word_sel;
  coord_t           org_x;
  coord_t           org_y;
  logic             show;
  logic             blink_en;
  logic             text_on;
  logic             busy_frame;

  modport master (
    output frame_start, video_on, pix_x, pix_y, word_sel, org_x, org_y,
           show, blink_en,
    input  text_on, busy_frame
  );

  modport slave (
    input  frame_start, video_on, pix_x, pix_y, word_sel, org_x, org_y,
           show, blink_en,
    output text_on, busy_frame
  );

endinterface

`default_nettype wire

// File: rtl/word_glyph_rom.sv
// +----------------------------------------------------------------------+
// | word_glyph_rom : combinational glyph store, MSB of a row = column 0  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module word_glyph_rom #(
  parameter int WORD_W    = 64,
  parameter int WORD_H    = 32,
  parameter int NUM_WORDS = 4,
  parameter int SEL_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  parameter int ROW_W     = (WORD_H > 1) ? $clog2(WORD_H) : 1
) (
  input  logic [SEL_W+ROW_W-1:0] addr,
  output logic [WORD_W-1:0]      row_bits
);

  logic [SEL_W-1:0]  word;
  logic [ROW_W-1:0]  row;
  logic              word_ok;
  logic [WORD_W-1:0] pattern;

  assign word = addr[SEL_W+ROW_W-1:ROW_W];
  assign row  = addr[ROW_W-1:0];

  if (NUM_WORDS >= (1 << SEL_W)) begin : g_sel_full
    assign word_ok = 1'b1;
  end else begin : g_sel_part
    assign word_ok = (word < SEL_W'(NUM_WORDS));
  end

  // Glyphs: 0 checkerboard, 1 top half, 2 left bar, others right bar.
  for (genvar c = 0; c < WORD_W; c++) begin : g_col
    localparam int   COL   = WORD_W - 1 - c;
    localparam logic ODD   = ((COL % 2) == 1);
    localparam logic LEFT  = (COL < 8);
    localparam logic RIGHT = (COL >= WORD_W - 8);

    assign pattern[c] = (word == SEL_W'(0)) ? (ODD == row[0]) :
                        (word == SEL_W'(1)) ? (row < ROW_W'(WORD_H / 2)) :
                        (word == SEL_W'(2)) ? LEFT : RIGHT;
  end

  // Unstored indices read as blank rows, never X.
  assign row_bits = word_ok ? pattern : '0;

endmodule

`default_nettype wire

// File: rtl/word_sprite.sv
// +----------------------------------------------------------------------+
// | word_sprite : frame-shadowed, scalable, blinking word-glyph overlay  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module word_sprite
  import word_sprite_pkg::*;
#(
  parameter int WORD_W       = DEF_WORD_W,
  parameter int WORD_H       = DEF_WORD_H,
  parameter int NUM_WORDS    = DEF_NUM_WORDS,
  parameter int SCALE_LOG2   = 0,
  parameter int BLINK_FRAMES = 30
) (
  input  logic          clk,
  input  logic          reset_n,
  word_sprite_if.slave  bus
);

  localparam int SEL_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int COL_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int ROW_W = (WORD_H > 1) ? $clog2(WORD_H) : 1;
  localparam int CNT_W = $clog2(BLINK_FRAMES + 1);
  localparam int unsigned SPAN_X = WORD_W << SCALE_LOG2;
  localparam int unsigned SPAN_Y = WORD_H << SCALE_LOG2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WORD_W - 1);

  logic [SEL_W-1:0] sel_q, sel_d;
  coord_t           org_x_q, org_x_d;
  coord_t           org_y_q, org_y_d;
  logic             armed_q, armed_d;
  blink_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en1_q, en1_d;
  logic [SEL_W-1:0] word1_q, word1_d;
  logic [ROW_W-1:0] row1_q, row1_d;
  logic [COL_W-1:0] bit1_q, bit1_d;
  logic             text_q, text_d;

  logic [10:0]       dx, dy;
  logic              hit, sel_ok, visible;
  logic [WORD_W-1:0] rom_row;

  if (NUM_WORDS >= (1 << SEL_W)) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_part
    assign sel_ok = (bus.word_sel < SEL_W'(NUM_WORDS));
  end

  always_comb begin
    sel_d   = sel_q;
    org_x_d = org_x_q;
    org_y_d = org_y_q;
    armed_d = armed_q;
    if (bus.frame_start) begin
      sel_d   = bus.word_sel;
      org_x_d = bus.org_x;
      org_y_d = bus.org_y;
      armed_d = bus.show & sel_ok;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!bus.blink_en) begin
      state_d = BLINK_SOLID;
      cnt_d   = '0;
    end else if (bus.frame_start) begin
      case (state_q)
        BLINK_SOLID: begin
          state_d = BLINK_ON;
          cnt_d   = '0;
        end
        BLINK_ON, BLINK_OFF: begin
          if (cnt_q == CNT_LAST) begin
            state_d = (state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = BLINK_SOLID;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Stage 1 uses the shadow values still held this cycle, so a pixel that
  // coincides with frame_start is drawn with the previous frame's settings.
  always_comb begin
    dx      = {1'b0, bus.pix_x} - {1'b0, org_x_q};
    dy      = {1'b0, bus.pix_y} - {1'b0, org_y_q};
    hit     = (bus.pix_x >= org_x_q) && (bus.pix_y >= org_y_q) &&
              (32'(dx) < SPAN_X) && (32'(dy) < SPAN_Y);
    visible = (state_q != BLINK_OFF);
    en1_d   = hit & bus.video_on & armed_q & visible;
    word1_d = sel_q;
    row1_d  = ROW_W'(dy >> SCALE_LOG2);
    bit1_d  = COL_LAST - COL_W'(dx >> SCALE_LOG2);
    text_d  = en1_q & rom_row[bit1_q];
  end

  word_glyph_rom #(
    .WORD_W    (WORD_W),
    .WORD_H    (WORD_H),
    .NUM_WORDS (NUM_WORDS)
  ) u_rom (
    .addr     ({word1_q, row1_q}),
    .row_bits (rom_row)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q   <= '0;
      org_x_q <= '0;
      org_y_q <= '0;
      armed_q <= 1'b0;
      state_q <= BLINK_SOLID;
      cnt_q   <= '0;
      en1_q   <= 1'b0;
      word1_q <= '0;
      row1_q  <= '0;
      bit1_q  <= '0;
      text_q  <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      org_x_q <= org_x_d;
      org_y_q <= org_y_d;
      armed_q <= armed_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en1_q   <= en1_d;
      word1_q <= word1_d;
      row1_q  <= row1_d;
      bit1_q  <= bit1_d;
      text_q  <= text_d;
    end
  end

  assign bus.text_on    = text_q;
  assign bus.busy_frame = armed_q;

endmodule

`default_nettype wire

// File: tb/tb_word_sprite.sv
// +----------------------------------------------------------------------+
// | tb_word_sprite : directed checks of word_sprite (two configurations) |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_word_sprite;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // if0/dut0: 3 words, unscaled, 2-frame blink. if1/dut1: 4 words, x2 scale.
  word_sprite_if #(.NUM_WORDS(3)) if0 ();
  word_sprite_if #(.NUM_WORDS(4)) if1 ();

  word_sprite #(
    .WORD_W(64), .WORD_H(32), .NUM_WORDS(3), .SCALE_LOG2(0), .BLINK_FRAMES(2)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0)
  );

  word_sprite #(
    .WORD_W(64), .WORD_H(32), .NUM_WORDS(4), .SCALE_LOG2(1), .BLINK_FRAMES(30)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1)
  );

  task automatic pulse_frame();
    if0.frame_start = 1'b1;
    if1.frame_start = 1'b1;
    @(posedge clk); #1;
    if0.frame_start = 1'b0;
    if1.frame_start = 1'b0;
  endtask

  task automatic set_glyph(input int d, input int sel, input int ox, input int oy);
    if (d == 0) begin
      if0.word_sel = 2'(sel); if0.org_x = 10'(ox); if0.org_y = 10'(oy); if0.show = 1'b1;
    end else begin
      if1.word_sel = 2'(sel); if1.org_x = 10'(ox); if1.org_y = 10'(oy); if1.show = 1'b1;
    end
  endtask

  // Presents one pixel and returns text_on two clocks later.
  task automatic probe(input int d, input int x, input int y, output logic got);
    if (d == 0) begin
      if0.pix_x = 10'(x); if0.pix_y = 10'(y); if0.video_on = 1'b1;
    end else begin
      if1.pix_x = 10'(x); if1.pix_y = 10'(y); if1.video_on = 1'b1;
    end
    @(posedge clk); @(posedge clk); #1;
    got = (d == 0) ? if0.text_on : if1.text_on;
  endtask

  task automatic test_reset();
    logic got;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (if0.text_on !== 1'b0) begin n_bad++; $display("FAIL reset_text0: got %b want 0", if0.text_on); end
    n_cmp++; if (if0.busy_frame !== 1'b0) begin n_bad++; $display("FAIL reset_busy0: got %b want 0", if0.busy_frame); end
    n_cmp++; if (if1.text_on !== 1'b0) begin n_bad++; $display("FAIL reset_text1: got %b want 0", if1.text_on); end
    n_cmp++; if (if1.busy_frame !== 1'b0) begin n_bad++; $display("FAIL reset_busy1: got %b want 0", if1.busy_frame); end
    reset_n = 1'b1;
    set_glyph(0, 0, 100, 50);
    probe(0, 100, 50, got);
    n_cmp++; if (got !== 1'b0) begin n_bad++; $display("FAIL reset_no_frame: got %b want 0", got); end
  endtask

  task automatic test_basic();
    int   xs[6] = '{100, 101, 164, 163,  99, 100};
    int   ys[6] = '{ 50,  50,  50,  51,  50,  49};
    logic ex[6] = '{  1,   0,   0,   1,   0,   0};
    logic got;
    set_glyph(0, 0, 100, 50);
    pulse_frame();
    n_cmp++; if (if0.busy_frame !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", if0.busy_frame); end
    for (int i = 0; i < 6; i++) begin
      probe(0, xs[i], ys[i], got);
      n_cmp++;
      if (got !== ex[i]) begin n_bad++; $display("FAIL basic_pix(%0d,%0d): got %b want %b", xs[i], ys[i], got, ex[i]); end
    end
  endtask

  task automatic test_latency();
    if0.video_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if0.pix_x = 10'd100; if0.pix_y = 10'd50; if0.video_on = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (if0.text_on !== 1'b0) begin n_bad++; $display("FAIL latency_early: got %b want 0", if0.text_on); end
    if0.pix_x = 10'd101;
    @(posedge clk); #1;
    n_cmp++; if (if0.text_on !== 1'b1) begin n_bad++; $display("FAIL latency_2clk: got %b want 1", if0.text_on); end
    @(posedge clk); #1;
    n_cmp++; if (if0.text_on !== 1'b0) begin n_bad++; $display("FAIL latency_next: got %b want 0", if0.text_on); end
  endtask

  task automatic test_words();
    logic got;
    set_glyph(0, 2, 100, 50);
    pulse_frame();
    probe(0, 107, 60, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL word2_col7: got %b want 1", got); end
    probe(0, 108, 60, got);
    n_cmp++; if (got !== 1'b0) begin n_bad++; $display("FAIL word2_col8: got %b want 0", got); end
    set_glyph(0, 1, 100, 50);
    pulse_frame();
    probe(0, 110, 65, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL word1_row15: got %b want 1", got); end
    probe(0, 110, 66, got);
    n_cmp++; if (got !== 1'b0) begin n_bad++; $display("FAIL word1_row16: got %b want 0", got); end
    if0.pix_x = 10'd110; if0.pix_y = 10'd65; if0.video_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (if0.text_on !== 1'b0) begin n_bad++; $display("FAIL word1_blanking: got %b want 0", if0.text_on); end
  endtask

  task automatic test_shadow();
    logic got;
    set_glyph(0, 0, 100, 50);
    pulse_frame();
    if0.org_x = 10'd200;
    probe(0, 100, 50, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL shadow_old_org: got %b want 1", got); end
    probe(0, 200, 50, got);
    n_cmp++; if (got !== 1'b0) begin n_bad++; $display("FAIL shadow_new_early: got %b want 0", got); end
    pulse_frame();
    probe(0, 200, 50, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL shadow_new_org: got %b want 1", got); end
    probe(0, 100, 50, got);
    n_cmp++; if (got !== 1'b0) begin n_bad++; $display("FAIL shadow_old_gone: got %b want 0", got); end
    // Pixel coincident with frame_start uses old origin; the next one the new.
    if0.pix_x = 10'd200; if0.pix_y = 10'd50; if0.video_on = 1'b1; if0.org_x = 10'd300;
    if0.frame_start = 1'b1; if1.frame_start = 1'b1;
    @(posedge clk); #1;
    if0.frame_start = 1'b0; if1.frame_start = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (if0.text_on !== 1'b1) begin n_bad++; $display("FAIL coincident_old: got %b want 1", if0.text_on); end
    @(posedge clk); #1;
    n_cmp++; if (if0.text_on !== 1'b0) begin n_bad++; $display("FAIL coincident_new: got %b want 0", if0.text_on); end
  endtask

  task automatic test_clip();
    int   xs[4] = '{1023, 1022, 5, 1000};
    int   ys[4] = '{1023, 1023, 5, 1010};
    logic ex[4] = '{   1,    0, 0,    1};
    logic got;
    set_glyph(0, 0, 1000, 1010);
    pulse_frame();
    for (int i = 0; i < 4; i++) begin
      probe(0, xs[i], ys[i], got);
      n_cmp++;
      if (got !== ex[i]) begin n_bad++; $display("FAIL clip_pix(%0d,%0d): got %b want %b", xs[i], ys[i], got, ex[i]); end
    end
  endtask

  task automatic test_blink();
    logic ex[8] = '{1, 1, 1, 0, 0, 1, 1, 0};
    logic got;
    set_glyph(0, 0, 100, 50);
    pulse_frame();
    if0.blink_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) pulse_frame();
      probe(0, 100, 50, got);
      n_cmp++;
      if (got !== ex[i]) begin n_bad++; $display("FAIL blink_step%0d: got %b want %b", i, got, ex[i]); end
    end
    n_cmp++; if (if0.busy_frame !== 1'b1) begin n_bad++; $display("FAIL blink_busy: got %b want 1", if0.busy_frame); end
    if0.blink_en = 1'b0;
    @(posedge clk); #1;
    probe(0, 100, 50, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL blink_solid: got %b want 1", got); end
  endtask

  task automatic test_scale();
    int   xs[6] = '{0, 1, 2, 128, 127, 127};
    int   ys[6] = '{0, 1, 0,   0,   2,  64};
    logic ex[6] = '{1, 1, 0,   0,   1,   0};
    logic got;
    set_glyph(1, 0, 0, 0);
    pulse_frame();
    for (int i = 0; i < 6; i++) begin
      probe(1, xs[i], ys[i], got);
      n_cmp++;
      if (got !== ex[i]) begin n_bad++; $display("FAIL scale_pix(%0d,%0d): got %b want %b", xs[i], ys[i], got, ex[i]); end
    end
    set_glyph(1, 3, 0, 0);
    pulse_frame();
    probe(1, 112, 0, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL scale_word3_col56: got %b want 1", got); end
    probe(1, 110, 0, got);
    n_cmp++; if (got !== 1'b0) begin n_bad++; $display("FAIL scale_word3_col55: got %b want 0", got); end
  endtask

  task automatic test_bad_sel();
    logic got;
    set_glyph(0, 3, 100, 50);
    pulse_frame();
    n_cmp++; if (if0.busy_frame !== 1'b0) begin n_bad++; $display("FAIL badsel_busy: got %b want 0", if0.busy_frame); end
    probe(0, 100, 50, got);
    n_cmp++; if (got !== 1'b0) begin n_bad++; $display("FAIL badsel_col0: got %b want 0", got); end
    probe(0, 163, 50, got);
    n_cmp++; if (got !== 1'b0) begin n_bad++; $display("FAIL badsel_col63: got %b want 0", got); end
    set_glyph(0, 0, 100, 50);
    if0.show = 1'b0;
    pulse_frame();
    n_cmp++; if (if0.busy_frame !== 1'b0) begin n_bad++; $display("FAIL noshow_busy: got %b want 0", if0.busy_frame); end
    probe(0, 100, 50, got);
    n_cmp++; if (got !== 1'b0) begin n_bad++; $display("FAIL noshow_text: got %b want 0", got); end
  endtask

  task automatic test_reset_midframe();
    logic got;
    set_glyph(0, 0, 100, 50);
    pulse_frame();
    probe(0, 100, 50, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL midreset_before: got %b want 1", got); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (if0.text_on !== 1'b0) begin n_bad++; $display("FAIL midreset_text: got %b want 0", if0.text_on); end
    n_cmp++; if (if0.busy_frame !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b want 0", if0.busy_frame); end
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      probe(0, 100, 50, got);
      n_cmp++;
      if (got !== 1'b0) begin n_bad++; $display("FAIL midreset_hold%0d: got %b want 0", i, got); end
    end
    pulse_frame();
    probe(0, 100, 50, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL midreset_rearm: got %b want 1", got); end
  endtask

  initial begin
    if0.frame_start = 1'b0; if0.video_on = 1'b0; if0.pix_x = '0; if0.pix_y = '0;
    if0.word_sel = '0; if0.org_x = '0; if0.org_y = '0; if0.show = 1'b0; if0.blink_en = 1'b0;
    if1.frame_start = 1'b0; if1.video_on = 1'b0; if1.pix_x = '0; if1.pix_y = '0;
    if1.word_sel = '0; if1.org_x = '0; if1.org_y = '0; if1.show = 1'b0; if1.blink_en = 1'b0;
    test_reset();
    test_basic();
    test_latency();
    test_words();
    test_shadow();
    test_clip();
    test_blink();
    test_scale();
    test_bad_sel();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/word_sprite.md
WORD_SPRITE -- requirements
Module: word_sprite

Interface
REQ-001 Parameter WORD_W, 64, glyph row width in pixels (bits per ROM row).
REQ-002 Parameter WORD_H, 32, glyph height in rows.
REQ-003 Parameter NUM_WORDS, 4, number of stored word glyphs.
REQ-004 Parameter SCALE_LOG2, 0, magnification: each glyph bit covers 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels.
REQ-005 Parameter BLINK_FRAMES, 30, frames per blink half-period.
REQ-006 clk  in  1  pixel-domain clock; the block's only clock.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 frame_start  in  1  one-cycle pulse at the first pixel of each frame.
REQ-009 video_on  in  1  high inside the visible area.
REQ-010 pix_x, pix_y  in  10 each  current pixel coordinates.
REQ-011 word_sel  in  clog2(NUM_WORDS)  requested glyph index.
REQ-012 org_x, org_y  in  10 each  requested top-left screen position of the glyph.
REQ-013 show  in  1  display enable.
REQ-014 blink_en  in  1  blink enable.
REQ-015 text_on  out  1  glyph pixel lit for the pixel presented two cycles earlier.
REQ-016 busy_frame  out  1  high while a shadowed glyph is armed for the current frame.

Function
REQ-017 The block SHALL sample word_sel, org_x, org_y and show into shadow registers only on a cycle with frame_start=1; changes at any other time SHALL have no effect until the next frame_start.
REQ-018 busy_frame SHALL be 1 from the cycle after a frame_start that latches show=1 with word_sel<NUM_WORDS, and 0 otherwise.
REQ-019 Hit test (stage 1): dx=pix_x-org_x and dy=pix_y-org_y, computed in 11-bit unsigned arithmetic; hit requires pix_x>=org_x, pix_y>=org_y, dx<(WORD_W<<SCALE_LOG2) and dy<(WORD_H<<SCALE_LOG2); a glyph extending past 1023 SHALL clip and SHALL NOT wrap.
REQ-020 col=dx>>SCALE_LOG2 and row=dy>>SCALE_LOG2; col 0 SHALL select the leftmost bit, which is the first-declared (MSB-end) bit of the ROM row.
REQ-021 Stage 2 SHALL register the ROM bit ANDed with the registered hit, video_on, busy_frame and the blink-visible flag; text_on therefore has a fixed latency of 2 clk.
REQ-022 Blink FSM states: SOLID, ON, OFF. When blink_en=0, the state SHALL be SOLID (visible) with the frame counter at 0. When blink_en=1 in SOLID, the FSM SHALL move to ON at the next frame_start. ON and OFF SHALL toggle after BLINK_FRAMES frame_start pulses; OFF is not visible.
REQ-023 The frame counter SHALL be ceil(log2(BLINK_FRAMES+1)) bits wide, SHALL return to 0 on each toggle and SHALL never overflow.
REQ-024 frame_start coincident with a visible pixel SHALL use the old shadow values for that pixel and the new values from the next cycle.
REQ-025 An out-of-range word_sel SHALL latch as disarmed (text_on=0 for the whole frame) and SHALL NOT produce an X from the ROM.

Reset
REQ-026 While reset_n=0, text_on, busy_frame, all pipeline registers and all shadow registers SHALL be 0, the FSM SHALL be SOLID and the counter 0.
REQ-027 After reset is released mid-frame, text_on SHALL stay 0 until the first frame_start that latches show=1.

Structure
REQ-028 The shared package SHALL hold the blink-state enum, the 10-bit coordinate type and the default glyph dimensions.
REQ-029 The glyph store SHALL be one sub-module, word_glyph_rom, addressed by {word, row}, returning a WORD_W-bit row, and purely combinational.

Verification
REQ-030 word_sel=0, org=(100,50), SCALE_LOG2=0, show=1: pixel (100,50) yields text_on equal to bit col0,row0 exactly 2 clk later, and pixel (164,50) yields text_on=0.
REQ-031 SCALE_LOG2=1, org=(0,0): pixels (0,0) and (1,1) both map to row0/col0; pixel (128,0) yields text_on=0.
REQ-032 org_x changed from 100 to 200 mid-frame: output is unchanged until frame_start, then the glyph starts at 200.
REQ-033 blink_en=1, BLINK_FRAMES=2: text_on is visible for 2 frames, blank for 2 frames, visible again; dropping blink_en returns to SOLID the next cycle.
REQ-034 org=(1000,1010): pixels (1023,1023) are lit per the ROM and there is no hit at (5,5).
REQ-035 reset_n pulsed low mid-frame: text_on=0 immediately and stays 0 until the next frame_start with show=1; word_sel=NUM_WORDS gives text_on=0 for the whole frame.
